// File: rtl/simple_processor_pkg.sv
// Shared encodings for simple_processor_Top and its instruction feeder:
// opcodes, instruction-word field layout and the fetch FSM state type.
package simple_processor_pkg;

    localparam int WORD_W  = 9;
    localparam int OPC_W   = 3;
    localparam int OPC_LSB = 0;
    localparam int RX_LSB  = 3;
    localparam int RY_LSB  = 6;

    localparam logic [OPC_W-1:0] OP_MV  = 3'b010;
    localparam logic [OPC_W-1:0] OP_MVI = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_IMM,
        ST_WAIT,
        ST_HALT
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] word_opc(input logic [WORD_W-1:0] w);
        return w[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [WORD_W-1:0] mk_word(input logic [2:0] ry,
                                                  input logic [2:0] rx,
                                                  input logic [OPC_W-1:0] opc);
        logic [WORD_W-1:0] w;
        w = '0;
        w[RY_LSB +: 3]        = ry;
        w[RX_LSB +: 3]        = rx;
        w[OPC_LSB +: OPC_W]   = opc;
        return w;
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Control, program-load and processor-side signals of the instruction feeder.
// master = the driver of start/program/Done (bench or system), slave = the sequencer.
interface instr_fetch_sequencer_if #(parameter int AW = 4);
    import simple_processor_pkg::*;

    logic              start;
    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [WORD_W-1:0] prog_data;
    logic [AW-1:0]     end_addr;
    logic              Done;

    logic [WORD_W-1:0] DIN;
    logic              Run;
    logic [AW-1:0]     pc;
    logic              busy;
    logic              halted;
    logic              err;

    modport master (
        output start, prog_we, prog_addr, prog_data, end_addr, Done,
        input  DIN, Run, pc, busy, halted, err
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_data, end_addr, Done,
        output DIN, Run, pc, busy, halted, err
    );
endinterface

// File: rtl/fetch_prog_mem.sv
// DEPTH x WORD_W program store: synchronous write, asynchronous read, contents not reset.
// Latency: a write is visible on the read port the cycle after the write edge.
module fetch_prog_mem #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int WORD_W = 9
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instr_fetch_sequencer.sv
// Feeds simple_processor_Top: issues program words (plus mvi immediates) on DIN/Run, then waits for Done.
// start->Run 2 cycles, Done->next Run 2 cycles; FETCH_DONE_TIMEOUT_EN adds a WAIT watchdog that aborts to HALT.
module instr_fetch_sequencer
    import simple_processor_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     Clock,
    input  logic                     Reset,
    instr_fetch_sequencer_if.slave   bus
);
    fetch_state_t      r_state;
    logic [WORD_W-1:0] r_din;
    logic              r_run;
    logic [AW-1:0]     r_pc;
    logic [AW-1:0]     r_last_addr;
    logic              r_busy;
    logic              r_halted;
    logic              r_err;

    logic [WORD_W-1:0] w_rdata;
    logic [OPC_W-1:0]  w_opc;
    logic              w_mem_we;
    logic              w_timeout;

    // Program loads only land while nothing is executing.
    assign w_mem_we = bus.prog_we & ~r_busy & ((r_state == ST_IDLE) | (r_state == ST_HALT));
    assign w_opc    = word_opc(w_rdata);

    fetch_prog_mem #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .WORD_W (WORD_W)
    ) u_mem (
        .i_clk   (Clock),
        .i_we    (w_mem_we),
        .i_waddr (bus.prog_addr),
        .i_wdata (bus.prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_rdata)
    );

`ifdef FETCH_DONE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_din       <= '0;
            r_run       <= 1'b0;
            r_pc        <= '0;
            r_last_addr <= '0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_run <= 1'b0;
                    if (bus.start) begin
                        r_pc    <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_din       <= w_rdata;
                    r_last_addr <= r_pc;
                    // An mvi with no following word is never handed to the processor.
                    if (w_opc == OP_MVI && r_pc == bus.end_addr) begin
                        r_run    <= 1'b0;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= ST_HALT;
                    end else begin
                        r_run   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_pc    <= r_pc + 1'b1;
                        r_state <= (w_opc == OP_MVI) ? ST_IMM : ST_WAIT;
                    end
                end
                ST_IMM: begin
                    r_din       <= w_rdata;
                    r_run       <= 1'b1;
                    r_last_addr <= r_pc;
                    r_pc        <= r_pc + 1'b1;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_run <= 1'b0;
                    if (bus.Done) begin
                        if (r_last_addr == bus.end_addr) begin
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end else if (w_timeout) begin
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    r_run  <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_halted <= 1'b0;
                        r_pc     <= '0;
                        r_state  <= ST_ISSUE;
                    end else begin
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_run   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.DIN    = r_din;
    assign bus.Run    = r_run;
    assign bus.pc     = r_pc;
    assign bus.busy   = r_busy;
    assign bus.halted = r_halted;
    assign bus.err    = r_err;
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer: load, issue, Done handshake, restart, reset and error paths.
module tb_instr_fetch_sequencer;
    import simple_processor_pkg::*;

    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    always #5 Clock = ~Clock;

    instr_fetch_sequencer_if #(.AW(4)) bus ();

    instr_fetch_sequencer #(.DEPTH(16), .AW(4), .TIMEOUT(64)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [8:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_done();
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
    endtask

    initial begin
        Reset         = 1'b1;
        bus.start     = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.end_addr  = '0;
        bus.Done      = 1'b0;
        tick();
        tick();
        chk("rst_din",    32'(bus.DIN),    0);
        chk("rst_run",    32'(bus.Run),    0);
        chk("rst_pc",     32'(bus.pc),     0);
        chk("rst_busy",   32'(bus.busy),   0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_err",    32'(bus.err),    0);
        Reset = 1'b0;
        tick();

        // mvi r0,#0x1CF as the whole program
        load(4'd0, 9'b011_000_001);
        load(4'd1, 9'b111_001_111);
        bus.end_addr = 4'd1;
        pulse_start();
        chk("t1_run_after_start", 32'(bus.Run), 0);
        tick();
        chk("t1_run_op",  32'(bus.Run),  1);
        chk("t1_din_op",  32'(bus.DIN),  'h0C1);
        chk("t1_pc_op",   32'(bus.pc),   1);
        chk("t1_busy_op", 32'(bus.busy), 1);
        tick();
        chk("t1_run_imm", 32'(bus.Run), 1);
        chk("t1_din_imm", 32'(bus.DIN), 'h1CF);
        chk("t1_pc_imm",  32'(bus.pc),  2);
        tick();
        chk("t1_run_wait", 32'(bus.Run), 0);
        chk("t1_din_held", 32'(bus.DIN), 'h1CF);
        tick();
        pulse_done();
        chk("t1_halted", 32'(bus.halted), 1);
        chk("t1_busy",   32'(bus.busy),   0);
        chk("t1_pc",     32'(bus.pc),     2);
        chk("t1_err",    32'(bus.err),    0);
        chk("t1_run",    32'(bus.Run),    0);

        // mv r5,r0 ; mvi r7,#0x1C7
        load(4'd0, mk_word(3'b000, 3'b101, OP_MV));
        load(4'd1, mk_word(3'b011, 3'b111, OP_MVI));
        load(4'd2, 9'b111_000_111);
        bus.end_addr = 4'd2;
        pulse_start();
        chk("t2_halted_clear", 32'(bus.halted), 0);
        tick();
        chk("t2_run_mv", 32'(bus.Run), 1);
        chk("t2_din_mv", 32'(bus.DIN), 'h02A);
        chk("t2_pc_mv",  32'(bus.pc),  1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_no_reissue", 32'(bus.Run), 0);
        end
        pulse_done();
        chk("t2_idle_gap", 32'(bus.Run), 0);
        tick();
        chk("t2_run_mvi", 32'(bus.Run), 1);
        chk("t2_din_mvi", 32'(bus.DIN), 'h0F9);
        tick();
        chk("t2_run_imm", 32'(bus.Run), 1);
        chk("t2_din_imm", 32'(bus.DIN), 'h1C7);
        chk("t2_pc_imm",  32'(bus.pc),  3);

        // prog_we and start while waiting must be ignored
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = 9'h1FF;
        bus.start     = 1'b1;
        tick();
        tick();
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
        chk("t3_run_busy_ignored", 32'(bus.Run),  0);
        chk("t3_pc_busy_ignored",  32'(bus.pc),   3);
        chk("t3_busy_held",        32'(bus.busy), 1);
        pulse_done();
        chk("t3_halted", 32'(bus.halted), 1);
        chk("t3_pc",     32'(bus.pc),     3);

        // restart from HALT re-issues word 0, which must be unchanged
        pulse_start();
        chk("t4_halted_clear", 32'(bus.halted), 0);
        chk("t4_pc_zero",      32'(bus.pc),     0);
        tick();
        chk("t4_din_reissue", 32'(bus.DIN),  'h02A);
        chk("t4_run_reissue", 32'(bus.Run),  1);
        chk("t4_busy",        32'(bus.busy), 1);

        // reset asserted mid-cycle while in IMM
        pulse_done();
        tick();
        chk("t5_din_mvi", 32'(bus.DIN), 'h0F9);
        #2 Reset = 1'b1;
        #1;
        chk("t5_run_async", 32'(bus.Run),  0);
        chk("t5_pc_async",  32'(bus.pc),   0);
        chk("t5_busy",      32'(bus.busy), 0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        tick();
        chk("t5_idle_run", 32'(bus.Run), 0);
        chk("t5_idle_pc",  32'(bus.pc),  0);

        // Done withheld after the first issue
        pulse_start();
        tick();
        chk("t6_run_mv", 32'(bus.Run), 1);
`ifdef FETCH_DONE_TIMEOUT_EN
        repeat (63) tick();
        chk("t6_not_yet_halted", 32'(bus.halted), 0);
        tick();
        chk("t6_timeout_err",    32'(bus.err),    1);
        chk("t6_timeout_halted", 32'(bus.halted), 1);
        chk("t6_timeout_busy",   32'(bus.busy),   0);
`else
        repeat (200) tick();
        chk("t6_wait_run",    32'(bus.Run),    0);
        chk("t6_wait_din",    32'(bus.DIN),    'h02A);
        chk("t6_wait_busy",   32'(bus.busy),   1);
        chk("t6_wait_halted", 32'(bus.halted), 0);
        chk("t6_wait_err",    32'(bus.err),    0);
`endif
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();

        // mvi as the last program word
        load(4'd0, 9'b011_111_001);
        load(4'd1, 9'b111_000_111);
        bus.end_addr = 4'd0;
        pulse_start();
        tick();
        chk("t7_err",    32'(bus.err),    1);
        chk("t7_halted", 32'(bus.halted), 1);
        chk("t7_run",    32'(bus.Run),    0);
        chk("t7_busy",   32'(bus.busy),   0);
        chk("t7_pc",     32'(bus.pc),     0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t7_no_imm_din", 32'(bus.DIN), 'h0F9);
            chk("t7_no_imm_run", 32'(bus.Run), 0);
        end
        chk("t7_err_sticky", 32'(bus.err), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
